// File: rtl/flash_rd_seq.sv
// SPI flash read sequencer: drives CS, shifts out READ opcode plus a 24-bit address,
// then requests bytes from the downstream receiver and streams them out with backpressure.
module flash_rd_seq #(
  parameter int unsigned HALF     = 5,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [23:0]      rd_addr,
  input  logic [LEN_W-1:0] rd_len,
  output logic             busy,
  output logic             done,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  output logic             tx_sclk,
  output logic             sclk_sel,
  output logic             rx_en,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] HALF_M1    = TW'(HALF - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(2 * HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TX,
    RX_START,
    RX_WAIT,
    OUT,
    HOLD
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q, timer_d;
  logic [4:0]       bit_q, bit_d;
  logic [31:0]      sr_q, sr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             cs_n_q, sclk_q, mosi_q, sel_q, rx_en_q;
  logic             busy_q, done_q, valid_q;
  logic [7:0]       data_q;

  always_comb begin
    timer_d = timer_q + 1'b1;
    bit_d   = bit_q + 1'b1;
    sr_d    = {sr_q[30:0], 1'b0};
    cnt_d   = cnt_q - 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      sel_q   <= 1'b0;
      rx_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      rx_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (rd_len != '0) begin
              sr_q    <= {8'h03, rd_addr};
              cnt_q   <= rd_len;
              busy_q  <= 1'b1;
              cs_n_q  <= 1'b0;
              timer_q <= '0;
              state_q <= SETUP;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (timer_q == SETUP_LAST) begin
            timer_q <= '0;
            bit_q   <= '0;
            mosi_q  <= sr_q[31];
            state_q <= TX;
          end else begin
            timer_q <= timer_d;
          end
        end
        TX: begin
          // Outputs are registered, so each edge sets up the value for the next phase.
          if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            sclk_q  <= 1'b0;
            if (bit_q == 5'd31) begin
              mosi_q  <= 1'b0;
              sel_q   <= 1'b1;
              rx_en_q <= 1'b1;
              state_q <= RX_START;
            end else begin
              bit_q  <= bit_d;
              sr_q   <= sr_d;
              mosi_q <= sr_q[30];
            end
          end else begin
            timer_q <= timer_d;
            if (timer_q == HALF_M1) sclk_q <= 1'b1;
          end
        end
        RX_START: begin
          state_q <= RX_WAIT;
        end
        RX_WAIT: begin
          if (rx_done) begin
            data_q  <= rx_data;
            valid_q <= 1'b1;
            cnt_q   <= cnt_d;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (rd_ready) begin
            valid_q <= 1'b0;
            if (cnt_q != '0) begin
              rx_en_q <= 1'b1;
              state_q <= RX_START;
            end else begin
              timer_q <= '0;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (timer_q == HOLD_LAST) begin
            cs_n_q  <= 1'b1;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;
  assign tx_sclk  = sclk_q;
  assign sclk_sel = sel_q;
  assign rx_en    = rx_en_q;
  assign rd_data  = data_q;
  assign rd_valid = valid_q;

endmodule

// File: tb/tb_flash_rd_seq.sv
// Randomised bench for flash_rd_seq: cycle-level reference model plus a receiver/flash stand-in.
module tb_flash_rd_seq;

  localparam int HALF     = 5;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int LEN_W    = 16;
  localparam int TX_END   = CS_SETUP + 64 * HALF;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             start   = 1'b0;
  logic [23:0]      rd_addr = '0;
  logic [LEN_W-1:0] rd_len  = '0;
  logic             rx_done = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rd_ready = 1'b0;
  logic             busy, done, spi_cs_n, spi_mosi, tx_sclk, sclk_sel, rx_en, rd_valid;
  logic [7:0]       rd_data;

  flash_rd_seq #(.HALF(HALF), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .LEN_W(LEN_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .rd_addr(rd_addr), .rd_len(rd_len),
    .busy(busy), .done(done), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .tx_sclk(tx_sclk),
    .sclk_sel(sclk_sel), .rx_en(rx_en), .rx_done(rx_done), .rx_data(rx_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: expected outputs for the cycle following each edge.
  bit          m_act = 0, m_cs = 1, m_busy = 0, m_done = 0, m_sel = 0;
  bit          m_rxen = 0, m_wait = 0, m_valid = 0;
  logic [7:0]  m_data = '0;
  logic [31:0] m_word = '0;
  int          m_left = 0, m_hold = 0, m_c = 0;
  bit          m_tx, m_sclk;

  task automatic model_step();
    m_done = 0;
    if (sys_rst) begin
      m_act = 0; m_cs = 1; m_busy = 0; m_sel = 0; m_rxen = 0;
      m_wait = 0; m_valid = 0; m_data = '0; m_hold = 0;
    end else if (!m_act) begin
      if (start) begin
        if (rd_len != 0) begin
          m_act = 1; m_c = 0; m_word = {8'h03, rd_addr}; m_left = int'(rd_len);
          m_cs = 0; m_busy = 1; m_wait = 0; m_hold = 0;
        end else begin
          m_done = 1;
        end
      end
    end else begin
      m_c++;
      if (m_rxen) begin
        m_rxen = 0; m_wait = 1;
      end else if (m_wait && rx_done) begin
        m_wait = 0; m_valid = 1; m_data = rx_data; m_left--;
      end else if (m_valid && rd_ready) begin
        m_valid = 0;
        if (m_left != 0) m_rxen = 1;
        else m_hold = CS_HOLD;
      end else if (m_hold != 0) begin
        m_hold--;
        if (m_hold == 0) begin
          m_act = 0; m_cs = 1; m_sel = 0; m_busy = 0; m_done = 1;
        end
      end
      if (m_c == TX_END) begin
        m_rxen = 1; m_sel = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    m_tx   = m_act && (m_c >= CS_SETUP) && (m_c < TX_END);
    m_sclk = m_tx && (((m_c - CS_SETUP) % (2 * HALF)) >= HALF);
    chk("spi_cs_n", 32'(spi_cs_n), 32'(m_cs));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("sclk_sel", 32'(sclk_sel), 32'(m_sel));
    chk("rx_en", 32'(rx_en), 32'(m_rxen));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_data", 32'(rd_data), 32'(m_data));
    chk("tx_sclk", 32'(tx_sclk), 32'(m_sclk));
    if (m_tx) chk("spi_mosi", 32'(spi_mosi), 32'(m_word[31 - (m_c - CS_SETUP) / (2 * HALF)]));
  end

  // Observation counters used by the directed literal checks.
  int         cyc = 0, rxen_cnt = 0, done_cnt = 0, busy_cyc = 0, fall_cnt = 0, valid_cyc = 0;
  int         fall_cyc = 0, rise_delta = -1, acc_cyc = 0, hold_delta = -1;
  logic [31:0] mosi_sr = '0;
  logic       prev_sclk = 1'b0, prev_cs = 1'b1;
  bit         rise_pend = 0;
  logic [7:0] got_q[$];

  initial forever begin
    @(negedge sys_clk);
    cyc++;
    if (rx_en) rxen_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    if (rd_valid) valid_cyc++;
    if (rd_valid && rd_ready) begin
      got_q.push_back(rd_data);
      acc_cyc = cyc;
    end
    if (!spi_cs_n && prev_cs) begin
      fall_cnt++; fall_cyc = cyc; rise_pend = 1;
    end
    if (spi_cs_n && !prev_cs) hold_delta = cyc - acc_cyc;
    if (tx_sclk && !prev_sclk) begin
      mosi_sr = {mosi_sr[30:0], spi_mosi};
      if (rise_pend) begin
        rise_delta = cyc - fall_cyc; rise_pend = 0;
      end
    end
    prev_sclk = tx_sclk;
    prev_cs   = spi_cs_n;
  end

  // Receiver stand-in: answers each rx_en after a random latency, plus stray rx_done pulses.
  logic [7:0] rx_q[$];
  int         lat;
  initial forever begin
    @(posedge sys_clk); #1;
    rx_done = 1'b0;
    if (rx_en) begin
      lat = $urandom_range(2, 25);
      repeat (lat) begin @(posedge sys_clk); #1; end
      rx_done = 1'b1;
      if (rx_q.size() != 0) rx_data = rx_q.pop_front();
      else rx_data = 8'($urandom_range(0, 255));
    end else if ($urandom_range(0, 39) == 0) begin
      rx_done = 1'b1;
      rx_data = 8'hEE;
    end
  end

  // rd_ready: 0 = always ready, 1 = random, 2 = stall 20 cycles per byte.
  int rdy_mode = 0;
  int stall = 0;
  initial forever begin
    @(posedge sys_clk); #1;
    case (rdy_mode)
      0: rd_ready = 1'b1;
      1: rd_ready = 1'($urandom_range(0, 1));
      default: begin
        if (rd_valid) begin
          if (stall < 20) begin rd_ready = 1'b0; stall++; end
          else rd_ready = 1'b1;
        end else begin
          rd_ready = 1'b0; stall = 0;
        end
      end
    endcase
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic launch(input logic [23:0] a, input int len);
    start = 1'b1; rd_addr = a; rd_len = LEN_W'(len);
    tick();
    start = 1'b0; rd_addr = 24'($urandom); rd_len = LEN_W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while (busy && n < 20000) begin tick(); n++; end
    if (busy) begin
      chk("idle_timeout", 32'(busy), 32'd0);
      sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    end
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, g0, v0, f0, b0, len;
    logic [23:0] a;

    // Reset values.
    repeat (3) tick();
    sys_rst = 1'b0;
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(tx_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_sel", 32'(sclk_sel), 32'd0);
    chk("rst_rx_en", 32'(rx_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    repeat (2) tick();

    // Single byte at 0x123456.
    rdy_mode = 0; tick();
    r0 = rxen_cnt; d0 = done_cnt; g0 = got_q.size();
    rx_q.push_back(8'h3C);
    launch(24'h123456, 1);
    wait_idle();
    chk("cmd_word", mosi_sr, 32'h03123456);
    chk("first_rise", 32'(rise_delta), 32'(CS_SETUP + HALF));
    chk("one_rx_en", 32'(rxen_cnt - r0), 32'd1);
    chk("one_done", 32'(done_cnt - d0), 32'd1);
    chk("one_byte", 32'(got_q[g0]), 32'h3C);

    // Three bytes, always ready.
    r0 = rxen_cnt; d0 = done_cnt; g0 = got_q.size(); v0 = valid_cyc;
    rx_q.push_back(8'hA5); rx_q.push_back(8'h5A); rx_q.push_back(8'hFF);
    launch(24'hABCDEF, 3);
    wait_idle();
    chk("seq3_b0", 32'(got_q[g0]), 32'hA5);
    chk("seq3_b1", 32'(got_q[g0+1]), 32'h5A);
    chk("seq3_b2", 32'(got_q[g0+2]), 32'hFF);
    chk("seq3_rx_en", 32'(rxen_cnt - r0), 32'd3);
    chk("seq3_done", 32'(done_cnt - d0), 32'd1);
    chk("seq3_valid_cyc", 32'(valid_cyc - v0), 32'd3);
    chk("seq3_hold", 32'(hold_delta), 32'(CS_HOLD + 1));

    // Three bytes, 20-cycle stall per byte.
    rdy_mode = 2; tick();
    r0 = rxen_cnt; g0 = got_q.size(); v0 = valid_cyc;
    rx_q.push_back(8'hA5); rx_q.push_back(8'h5A); rx_q.push_back(8'hFF);
    launch(24'h000010, 3);
    wait_idle();
    chk("stall_b0", 32'(got_q[g0]), 32'hA5);
    chk("stall_b1", 32'(got_q[g0+1]), 32'h5A);
    chk("stall_b2", 32'(got_q[g0+2]), 32'hFF);
    chk("stall_rx_en", 32'(rxen_cnt - r0), 32'd3);
    chk("stall_valid_cyc", 32'(valid_cyc - v0), 32'd63);
    chk("stall_hold", 32'(hold_delta), 32'(CS_HOLD + 1));

    // Zero-length request.
    rdy_mode = 0; tick();
    r0 = rxen_cnt; d0 = done_cnt; f0 = fall_cnt; b0 = busy_cyc;
    launch(24'h777777, 0);
    chk("len0_done_next", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("len0_no_cs", 32'(fall_cnt - f0), 32'd0);
    chk("len0_no_rx_en", 32'(rxen_cnt - r0), 32'd0);
    chk("len0_busy_cyc", 32'(busy_cyc - b0), 32'd0);
    chk("len0_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Start pulsed mid-transaction is ignored.
    r0 = rxen_cnt; d0 = done_cnt; g0 = got_q.size();
    for (int i = 0; i < 4; i++) rx_q.push_back(8'(8'h40 + i));
    launch(24'h89ABCD, 4);
    repeat (100) tick();
    start = 1'b1; rd_addr = 24'h000000; rd_len = LEN_W'(7);
    tick();
    start = 1'b0;
    wait_idle();
    chk("mid_word", mosi_sr, 32'h0389ABCD);
    chk("mid_bytes", 32'(got_q.size() - g0), 32'd4);
    chk("mid_rx_en", 32'(rxen_cnt - r0), 32'd4);
    chk("mid_done", 32'(done_cnt - d0), 32'd1);

    // Reset during TX, then a clean transaction.
    launch(24'h55AA55, 2);
    repeat (150) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
    chk("abort_sclk", 32'(tx_sclk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(rd_valid), 32'd0);
    chk("abort_sel", 32'(sclk_sel), 32'd0);
    repeat (3) tick();
    g0 = got_q.size();
    rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    launch(24'h000100, 2);
    wait_idle();
    chk("after_abort_word", mosi_sr, 32'h03000100);
    chk("after_abort_b0", 32'(got_q[g0]), 32'h11);
    chk("after_abort_b1", 32'(got_q[g0+1]), 32'h22);

    // Random transactions, random backpressure, occasional ignored starts.
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) begin
      d0 = done_cnt; g0 = got_q.size();
      a = 24'($urandom);
      len = $urandom_range(0, 5);
      launch(a, len);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 300)) tick();
        if (busy) begin
          start = 1'b1; rd_addr = 24'($urandom); rd_len = LEN_W'($urandom_range(0, 9));
          tick();
          start = 1'b0;
        end
      end
      wait_idle();
      chk("rand_done", 32'(done_cnt - d0), 32'd1);
      chk("rand_bytes", 32'(got_q.size() - g0), 32'(len));
      if (len != 0) chk("rand_word", mosi_sr, {8'h03, a});
      repeat ($urandom_range(0, 6)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_rd_seq.md
Name: flash_rd_seq

Overview:
- Read-transaction sequencer for the SPI flash path, directly downstream of the byte receiver (spi_rx), which it controls and consumes.
- On a start pulse it:
  - asserts chip select;
  - shifts out the READ opcode (0x03) and a 24-bit address on MOSI with its own bit engine;
  - issues one rx_en pulse per requested byte to the receiver;
  - delivers each received byte on a valid/ready stream with backpressure.
- Top level muxes spi_sclk: tx_sclk from this block when sclk_sel=0, receiver's sclk when sclk_sel=1.

Parameters:
HALF, 5, sys_clk cycles per SCLK half-period on transmit (must equal the receiver's HALF)
CS_SETUP, 4, cycles from spi_cs_n falling to first tx_sclk activity
CS_HOLD, 4, cycles from last received byte accepted to spi_cs_n rising
LEN_W, 16, width of byte-count input

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
rd_addr  in  24  flash byte address, captured on accepted start
rd_len  in  LEN_W  bytes to read, captured on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of transaction
spi_cs_n  out  1  flash chip select, active low
spi_mosi  out  1  serial command/address data, MSB first
tx_sclk  out  1  SCLK during command/address phase, idle low (mode 0)
sclk_sel  out  1  0: tx_sclk drives pin; 1: receiver sclk drives pin
rx_en  out  1  one-cycle pulse starting one receiver byte
rx_done  in  1  receiver byte-complete pulse; rx_data valid same cycle
rx_data  in  8  received byte
rd_data  out  8  output byte
rd_valid  out  1  output byte valid
rd_ready  in  1  downstream accept

Behaviour:
- Clocking and reset:
  - One clock, sys_clk.
  - sys_rst is synchronous active-high; it dominates all other inputs and aborts any transaction mid-flight.
- Reset values:
  - spi_cs_n=1, tx_sclk=0, spi_mosi=0, sclk_sel=0.
  - rx_en=0, busy=0, done=0, rd_valid=0, rd_data=0.
  - FSM in IDLE.
- FSM states: IDLE, SETUP, TX, RX_START, RX_WAIT, OUT, HOLD.
- IDLE:
  - start=1 with rd_len!=0: capture shift register {8'h03, rd_addr} and remaining count=rd_len; busy=1 and spi_cs_n=0 next cycle; go to SETUP.
  - start=1 with rd_len=0: no bus activity (spi_cs_n stays 1); done pulses the next cycle; busy stays 0.
- SETUP:
  - Wait CS_SETUP cycles, then go to TX.
- TX:
  - 32 bits; each bit lasts 2*HALF cycles.
  - Phase 0: spi_mosi=current MSB, tx_sclk=0.
  - Phase HALF: tx_sclk=1.
  - After the last bit's high phase completes: tx_sclk=0, sclk_sel=1, go to RX_START.
  - First tx_sclk rise occurs HALF cycles after TX entry; total TX time is exactly 64*HALF cycles.
- RX_START:
  - Pulse rx_en for exactly one cycle, then go to RX_WAIT.
- RX_WAIT:
  - On rx_done: rd_data<=rx_data, rd_valid<=1, decrement count, go to OUT.
  - rx_done arriving in any other state is ignored.
- OUT:
  - Hold rd_data and rd_valid stable until rd_ready=1; the SPI clock is stalled meanwhile.
  - On the handshake (rd_valid & rd_ready): rd_valid<=0.
    - count!=0 → RX_START.
    - count=0 → HOLD.
- HOLD:
  - Wait CS_HOLD cycles, then spi_cs_n<=1, sclk_sel<=0, busy<=0.
  - done pulses on the same cycle spi_cs_n rises; go to IDLE.
- Start handling: start while busy is ignored; no queuing.
- Count width: count is LEN_W bits; max transaction is 2^LEN_W-1 bytes. Flash address wrap beyond 0xFFFFFF is handled by the flash, not this block.
- Reset mid-transaction: all outputs return to reset values the next edge. No partial byte is delivered; a pending rd_valid is dropped.

Test Plan:
- Reset with busy=1 in TX → next cycle spi_cs_n=1, tx_sclk=0, busy=0, rd_valid=0; FSM idle; a later start works normally.
- start, rd_addr=0x123456, rd_len=1, HALF=5 → MOSI sampled on 32 tx_sclk rises = 0x03123456; first rise 5 cycles after TX entry; one rx_en pulse.
- Flash model returns 0xA5, 0x5A, 0xFF with rd_len=3 and rd_ready=1 → rd_data sequence A5, 5A, FF, one rd_valid cycle each; exactly 3 rx_en pulses; done once; spi_cs_n rises CS_HOLD cycles after the last accept.
- Same as above but rd_ready held low 20 cycles per byte → rd_valid/rd_data stable throughout; next rx_en issued only after the accept; data unchanged.
- rd_len=0 → spi_cs_n never falls, no rx_en, done pulses the cycle after start, busy stays 0.
- start pulsed again mid-transaction with rd_addr=0x000000 → ignored; transaction completes with original address and length.
